// File: rtl/shift_rows_if.sv
// Stream bundle between SubBytes and MixColumns around the ShiftRows stage.
// The slave side is the ShiftRows block; the master side is its environment.
interface shift_rows_if #(
    parameter int NB = 4
);
    localparam int W = 32 * NB;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_inv;

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_inv
    );

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_inv
    );
endinterface

// File: rtl/shift_rows_pipe.sv
// Registered Rijndael ShiftRows / InvShiftRows for Nb = 4, 6 or 8 columns.
// The byte permutation is applied on the input side, so both the main
// register and the skid register hold already-permuted states. in_ready
// comes straight from the skid valid flop, breaking the out_ready path.
module shift_rows_pipe #(
    parameter int NB = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    shift_rows_if.slave bus
);
    localparam int W = 32 * NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    // Row rotation amount; the 8-column variant skips offset 2.
    function automatic int row_shift(input int r);
        if (NB == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    // Byte k = r + 4c sits at bits [W-1-8k -: 8]; forward reads column
    // c + sh(r), inverse reads column c - sh(r), both modulo NB.
    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d,
                                                input logic         inv);
        logic [W-1:0] o;
        int           src;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) src = (c - row_shift(r) + NB) % NB;
                else     src = (c + row_shift(r)) % NB;
                o[W-1-8*(r+4*c) -: 8] = d[W-1-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    logic [W-1:0] perm_p0;
    logic [W-1:0] m_data_p1;
    logic         m_inv_p1;
    logic         m_vld_p1;
    logic [W-1:0] s_data_p1;
    logic         s_inv_p1;
    logic         s_vld_p1;

    logic accept;
    logic xfer;
    logic load_m_from_s;
    logic load_m_from_in;
    logic load_s;

    assign perm_p0 = shift_rows(bus.in_data, bus.in_inv);

    assign bus.in_ready  = !s_vld_p1;
    assign bus.out_valid = m_vld_p1;
    assign bus.out_data  = m_data_p1;
    assign bus.out_inv   = m_inv_p1;

    // Decode which register captures what on the coming edge.
    always_comb begin
        accept         = bus.in_valid && !s_vld_p1;
        xfer           = m_vld_p1 && bus.out_ready;
        load_m_from_s  = xfer && s_vld_p1;
        load_m_from_in = accept && (!m_vld_p1 || (xfer && !s_vld_p1));
        load_s         = accept && m_vld_p1 && !xfer;
    end

    // ---- stage p0 -> p1 boundary: occupancy flags ----
    // Valid bits of the main and skid registers; flush empties both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld_p1 <= 1'b0;
            s_vld_p1 <= 1'b0;
        end else if (flush) begin
            m_vld_p1 <= 1'b0;
            s_vld_p1 <= 1'b0;
        end else if (xfer) begin
            if (s_vld_p1) begin
                m_vld_p1 <= 1'b1;
                s_vld_p1 <= 1'b0;
            end else begin
                m_vld_p1 <= accept;
            end
        end else if (!m_vld_p1) begin
            m_vld_p1 <= accept;
        end else if (accept) begin
            s_vld_p1 <= 1'b1;
        end
    end

    // Main register payload; cleared by reset so out_data reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_p1 <= '0;
            m_inv_p1  <= 1'b0;
        end else if (load_m_from_s) begin
            m_data_p1 <= s_data_p1;
            m_inv_p1  <= s_inv_p1;
        end else if (load_m_from_in) begin
            m_data_p1 <= perm_p0;
            m_inv_p1  <= bus.in_inv;
        end
    end

    // Skid register payload; its content only matters while s_vld_p1 is set.
    always_ff @(posedge clk) begin
        if (load_s) begin
            s_data_p1 <= perm_p0;
            s_inv_p1  <= bus.in_inv;
        end
    end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: FIPS-197 vectors on NB=4, offset and round-trip
// checks on NB=8, and a queue-based stream model on NB=6 covering
// backpressure, flush, asynchronous reset and a long random stream.
module tb_shift_rows_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush4, flush6, flush8;

    shift_rows_if #(.NB(4)) if4();
    shift_rows_if #(.NB(6)) if6();
    shift_rows_if #(.NB(8)) if8();

    shift_rows_pipe #(.NB(4)) u4 (.clk(clk), .rst_n(rst_n), .flush(flush4), .bus(if4));
    shift_rows_pipe #(.NB(6)) u6 (.clk(clk), .rst_n(rst_n), .flush(flush6), .bus(if6));
    shift_rows_pipe #(.NB(8)) u8 (.clk(clk), .rst_n(rst_n), .flush(flush8), .bus(if8));

    typedef struct {
        logic [255:0] data;
        logic         inv;
    } blk_t;

    int   tests_run    = 0;
    int   tests_failed = 0;
    blk_t q6[$];
    int   popped6;
    logic [255:0] d8;
    logic [255:0] echo8;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ShiftRows: split the state into rows and rotate each row
    // one byte at a time (left for forward, right for inverse).
    function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input logic inv);
        logic [7:0]   b[32];
        logic [7:0]   row[8];
        logic [7:0]   tmp;
        logic [255:0] o;
        int           w;
        int           sh;
        w = 32 * nb;
        o = '0;
        for (int k = 0; k < 4 * nb; k++) b[k] = d[w-1-8*k -: 8];
        for (int r = 0; r < 4; r++) begin
            sh = (nb == 8 && r >= 2) ? r + 1 : r;
            for (int c = 0; c < nb; c++) row[c] = b[r + 4 * c];
            for (int s = 0; s < sh; s++) begin
                if (!inv) begin
                    tmp = row[0];
                    for (int c = 0; c < nb - 1; c++) row[c] = row[c + 1];
                    row[nb - 1] = tmp;
                end else begin
                    tmp = row[nb - 1];
                    for (int c = nb - 1; c > 0; c--) row[c] = row[c - 1];
                    row[0] = tmp;
                end
            end
            for (int c = 0; c < nb; c++) o[w-1-8*(r+4*c) -: 8] = row[c];
        end
        return o;
    endfunction

    // One NB=6 cycle: compare outputs to the model, then advance the model
    // with the handshakes that the coming edge will perform.
    task automatic tick6();
        bit acc;
        bit xfr;
        @(negedge clk);
        check("nb6_in_ready", {255'd0, if6.in_ready}, {255'd0, q6.size() < 2});
        check("nb6_out_valid", {255'd0, if6.out_valid}, {255'd0, q6.size() > 0});
        if (q6.size() > 0) begin
            check("nb6_out_data", {64'd0, if6.out_data}, q6[0].data);
            check("nb6_out_inv", {255'd0, if6.out_inv}, {255'd0, q6[0].inv});
        end
        acc = if6.in_valid && (q6.size() < 2);
        xfr = (q6.size() > 0) && if6.out_ready;
        if (flush6) begin
            q6.delete();
        end else begin
            if (xfr) begin
                void'(q6.pop_front());
                popped6++;
            end
            if (acc) q6.push_back(blk_t'{ref_shift({64'd0, if6.in_data}, 6, if6.in_inv), if6.in_inv});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer6(input logic [191:0] d, input logic inv);
        if6.in_valid = 1'b1;
        if6.in_data  = d;
        if6.in_inv   = inv;
    endtask

    initial begin
        int cycles;
        rst_n  = 1'b0;
        flush4 = 1'b0;
        flush6 = 1'b0;
        flush8 = 1'b0;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.in_inv = 1'b0; if4.out_ready = 1'b1;
        if6.in_valid = 1'b0; if6.in_data = '0; if6.in_inv = 1'b0; if6.out_ready = 1'b0;
        if8.in_valid = 1'b0; if8.in_data = '0; if8.in_inv = 1'b0; if8.out_ready = 1'b1;
        popped6 = 0;

        // Reset state, observed while reset is asserted.
        #12;
        check("rst_out_valid", {255'd0, if4.out_valid}, 256'd0);
        check("rst_out_data", {128'd0, if4.out_data}, 256'd0);
        check("rst_out_inv", {255'd0, if4.out_inv}, 256'd0);
        check("rst_in_ready", {255'd0, if4.in_ready}, 256'd1);
        check("rst_in_ready6", {255'd0, if6.in_ready}, 256'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {255'd0, if4.in_ready}, 256'd1);

        // FIPS-197 forward and inverse vectors, NB=4.
        if4.in_valid = 1'b1;
        if4.in_inv   = 1'b0;
        if4.in_data  = 128'hd42711aee0bf98f1b8b45de51e415230;
        @(posedge clk);
        #1;
        check("fips_fwd_valid", {255'd0, if4.out_valid}, 256'd1);
        check("fips_fwd_data", {128'd0, if4.out_data}, {128'd0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
        check("fips_fwd_inv", {255'd0, if4.out_inv}, 256'd0);
        if4.in_inv  = 1'b1;
        if4.in_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        @(posedge clk);
        #1;
        check("fips_inv_data", {128'd0, if4.out_data}, {128'd0, 128'hd42711aee0bf98f1b8b45de51e415230});
        check("fips_inv_inv", {255'd0, if4.out_inv}, 256'd1);
        if4.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fips_drained", {255'd0, if4.out_valid}, 256'd0);

        // NB=8 offsets and round trip.
        d8 = '0;
        for (int k = 0; k < 32; k++) d8[255-8*k -: 8] = 8'(k);
        if8.in_valid = 1'b1;
        if8.in_inv   = 1'b0;
        if8.in_data  = d8;
        @(posedge clk);
        #1;
        check("nb8_col0", {224'd0, if8.out_data[255:224]}, {224'd0, 32'h00050e13});
        check("nb8_fwd", if8.out_data, ref_shift(d8, 8, 1'b0));
        echo8 = if8.out_data;
        if8.in_data = echo8;
        if8.in_inv  = 1'b1;
        @(posedge clk);
        #1;
        check("nb8_roundtrip", if8.out_data, d8);
        check("nb8_rt_inv", {255'd0, if8.out_inv}, 256'd1);
        if8.in_valid = 1'b0;

        // Backpressure: A, B accepted, C held until the stall lifts.
        if6.out_ready = 1'b0;
        popped6 = 0;
        offer6({6{32'hA0A1A2A3}} ^ 192'h0123456789abcdef0011223344556677, 1'b0);
        tick6();
        offer6({6{32'hB0B1B2B3}} ^ 192'hfedcba98765432100f1e2d3c4b5a6978, 1'b1);
        tick6();
        offer6({6{32'hC0C1C2C3}} ^ 192'h13579bdf2468ace0aa55aa55aa55aa55, 1'b0);
        tick6();
        tick6();
        tick6();
        check("bp_c_held", {255'd0, if6.in_ready}, 256'd0);
        if6.out_ready = 1'b1;
        tick6();
        tick6();
        if6.in_valid = 1'b0;
        tick6();
        tick6();
        check("bp_count", 256'(popped6), 256'd3);

        // Flush with both registers full; the block offered alongside is dropped.
        if6.out_ready = 1'b0;
        offer6({6{32'h11111111}}, 1'b0);
        tick6();
        offer6({6{32'h22222222}}, 1'b1);
        tick6();
        flush6 = 1'b1;
        offer6({6{32'h33333333}}, 1'b0);
        tick6();
        flush6 = 1'b0;
        if6.in_valid = 1'b0;
        if6.out_ready = 1'b1;
        tick6();
        tick6();

        // Flush with only the main register full and an acceptable offer.
        if6.out_ready = 1'b0;
        offer6({6{32'h44444444}}, 1'b1);
        tick6();
        flush6 = 1'b1;
        offer6({6{32'h55555555}}, 1'b0);
        tick6();
        flush6 = 1'b0;
        if6.in_valid = 1'b0;
        if6.out_ready = 1'b1;
        tick6();
        tick6();

        // Asynchronous reset mid-stream, checked between clock edges.
        if6.out_ready = 1'b0;
        offer6({6{32'h5a5aa5a5}}, 1'b1);
        tick6();
        if6.in_valid = 1'b0;
        tick6();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {255'd0, if6.out_valid}, 256'd0);
        check("arst_out_data", {64'd0, if6.out_data}, 256'd0);
        check("arst_out_inv", {255'd0, if6.out_inv}, 256'd0);
        check("arst_in_ready", {255'd0, if6.in_ready}, 256'd1);
        q6.delete();
        #1;
        rst_n = 1'b1;
        tick6();

        // Random NB=6 stream of 1000 delivered blocks.
        popped6 = 0;
        cycles  = 0;
        while (popped6 < 1000 && cycles < 20000) begin
            if6.in_valid  = ($urandom_range(3) != 0);
            if6.in_inv    = $urandom_range(1) == 1;
            if6.in_data   = if6.in_valid ? {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}
                                         : 'x;
            if6.out_ready = ($urandom_range(2) != 0);
            tick6();
            cycles++;
        end
        check("rand_count", 256'(popped6), 256'd1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
